// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-stage data-access unit of the 5-stage MIPS pipeline.
// Issues loads and stores on an SRAM-like bus, checks alignment, extends load
// data and stalls the pipeline until the access completes. Flushes that arrive
// while a transaction is outstanding are absorbed by draining the response.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   valid_m, mem_read,      memory-stage instruction qualifiers
//   mem_write, mem_op
//   alu_out, store_data     effective address / non-memory result, store value
//   flush, hold             memory-stage flush, downstream stall
//   data_*                  SRAM-like data bus (request + response)
//   result_m                value forwarded to ResultMOut
//   stall_m                 freeze upstream pipeline registers
//   adel, ades, badvaddr    address-error exceptions and faulting address
//
// state | meaning
// IDLE  | no transaction; request driven combinationally when an access is valid
// ADDR  | request held, waiting for addr_ok
// DATA  | address accepted, waiting for data_ok
// DONE  | response captured; result presented until the pipeline advances
// DRAIN | flushed while outstanding; waiting to swallow the response

module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_m,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic              flush,
  input  logic              hold,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] result_m,
  output logic              stall_m,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic              load_q, load_d;

  logic [1:0]        size;
  logic              misaligned;
  logic              acc;
  logic              req;
  logic              stall;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] ext_v;

  always_comb begin
    case (mem_op)
      3'b000, 3'b001: size = 2'd0;
      3'b010, 3'b011: size = 2'd1;
      default:        size = 2'd2;
    endcase
  end

  assign misaligned = ((size == 2'd1) && alu_out[0]) ||
                      ((size == 2'd2) && (alu_out[1:0] != 2'b00));
  assign acc = valid_m & (mem_read | mem_write) & ~misaligned & ~flush;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    op_d    = op_q;
    lane_d  = lane_q;
    load_d  = load_q;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        req   = acc;
        stall = acc;
        if (acc) begin
          // op and byte lane are captured at issue so extension in DONE does
          // not depend on the upstream register staying put.
          op_d    = mem_op;
          lane_d  = alu_out[1:0];
          load_d  = mem_read;
          state_d = data_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        stall = 1'b1;
        if (flush) begin
          // request withdrawn before it was ever accepted
          state_d = IDLE;
        end else begin
          req = 1'b1;
          if (data_addr_ok) state_d = DATA;
        end
      end
      DATA: begin
        stall = 1'b1;
        if (data_data_ok) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            buf_d   = data_rdata;
            state_d = DONE;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (data_data_ok) state_d = IDLE;
      end
      DONE: begin
        if (!hold || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      op_q    <= '0;
      lane_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_v = buf_q[7:0];
      2'd1:    byte_v = buf_q[15:8];
      2'd2:    byte_v = buf_q[23:16];
      default: byte_v = buf_q[31:24];
    endcase
    half_v = lane_q[1] ? buf_q[31:16] : buf_q[15:0];
    case (op_q)
      3'b000:  ext_v = {{(DATA_W-8){byte_v[7]}}, byte_v};
      3'b001:  ext_v = {{(DATA_W-8){1'b0}}, byte_v};
      3'b010:  ext_v = {{(DATA_W-16){half_v[15]}}, half_v};
      3'b011:  ext_v = {{(DATA_W-16){1'b0}}, half_v};
      default: ext_v = buf_q;
    endcase
  end

  always_comb begin
    case (size)
      2'd0:    data_wdata = {4{store_data[7:0]}};
      2'd1:    data_wdata = {2{store_data[15:0]}};
      default: data_wdata = store_data;
    endcase
  end

  assign data_addr = alu_out;
  assign data_wr   = mem_write;
  assign data_size = size;
  assign badvaddr  = alu_out;

  assign data_req = req & ~reset;
  assign stall_m  = stall & ~reset;
  assign adel     = valid_m & mem_read & misaligned & ~reset;
  assign ades     = valid_m & mem_write & misaligned & ~reset;

  assign result_m = ((state_q == DONE) && load_q) ? ext_v : DATA_W'(alu_out);

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m, mem_read, mem_write, flush, hold;
  logic [2:0]  mem_op;
  logic [31:0] alu_out, store_data;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, result_m, badvaddr;
  logic        stall_m, adel, ades;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .mem_read(mem_read),
    .mem_write(mem_write), .mem_op(mem_op), .alu_out(alu_out),
    .store_data(store_data), .flush(flush), .hold(hold),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .result_m(result_m), .stall_m(stall_m),
    .adel(adel), .ades(ades), .badvaddr(badvaddr)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- reference model (transaction level) ----------------
  function automatic int unsigned size_model(input logic [2:0] op);
    if (op < 3'd2) return 0;
    if (op < 3'd4) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] ext_model(input logic [31:0] rd, input logic [2:0] op,
                                            input logic [31:0] a);
    logic [31:0] v;
    int unsigned sh;
    if (op < 3'd2) begin
      sh = 8 * int'(a % 4);
      v  = (rd >> sh) & 32'hFF;
      if (op == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (op < 3'd4) begin
      sh = 16 * int'((a / 2) % 2);
      v  = (rd >> sh) & 32'hFFFF;
      if (op == 3'd2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] wdata_model(input logic [31:0] sd, input logic [2:0] op);
    int unsigned s;
    s = size_model(op);
    if (s == 0) return (sd & 32'hFF) * 32'h0101_0101;
    if (s == 1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  // One complete aligned access: da cycles without addr_ok, dd cycles without
  // data_ok, hc cycles of hold in DONE. Entered and left at posedge+1.
  task automatic do_access(input bit ld, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input int da, input int dd, input int hc);
    logic [31:0] exp_res;
    exp_res    = ld ? ext_model(rd, op, addr) : addr;
    valid_m    = 1'b1; mem_read = ld; mem_write = !ld; mem_op = op;
    alu_out    = addr; store_data = sd; flush = 1'b0; hold = 1'b0;
    for (int k = 0; k <= da; k++) begin
      data_addr_ok = (k == da); data_data_ok = 1'b0; data_rdata = $urandom;
      #1;
      checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL issue_req: got %b want 1", data_req); end
      checks++; if (stall_m !== 1'b1) begin errors++; $display("FAIL issue_stall: got %b want 1", stall_m); end
      if (k == 0) begin
        checks++; if (data_addr !== addr) begin errors++; $display("FAIL bus_addr: got %h want %h", data_addr, addr); end
        checks++; if (data_size !== 2'(size_model(op))) begin errors++; $display("FAIL bus_size: got %0d want %0d", data_size, size_model(op)); end
        checks++; if (data_wr !== !ld) begin errors++; $display("FAIL bus_wr: got %b want %b", data_wr, !ld); end
        if (!ld) begin
          checks++; if (data_wdata !== wdata_model(sd, op)) begin errors++; $display("FAIL bus_wdata: got %h want %h", data_wdata, wdata_model(sd, op)); end
        end
      end
      @(posedge clk); #1;
    end
    for (int j = 0; j <= dd; j++) begin
      data_addr_ok = 1'($urandom % 2); data_data_ok = (j == dd);
      data_rdata = (j == dd) ? rd : $urandom;
      #1;
      checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL wait_req: got %b want 0", data_req); end
      checks++; if (stall_m !== 1'b1) begin errors++; $display("FAIL wait_stall: got %b want 1", stall_m); end
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0;
    for (int h = 0; h <= hc; h++) begin
      hold = (h < hc); data_data_ok = 1'($urandom % 2); data_rdata = $urandom;
      #1;
      checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL done_stall: got %b want 0", stall_m); end
      checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL done_req: got %b want 0", data_req); end
      checks++; if (result_m !== exp_res) begin errors++; $display("FAIL done_result: got %h want %h", result_m, exp_res); end
      @(posedge clk); #1;
    end
    hold = 1'b0; data_data_ok = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; valid_m = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_op = 3'd4;
    alu_out = 32'h0000_1001; store_data = 32'h0; flush = 1'b0; hold = 1'b0;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", data_req); end
    checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_m); end
    checks++; if (adel !== 1'b0) begin errors++; $display("FAIL reset_adel: got %b want 0", adel); end
    checks++; if (result_m !== 32'h0000_1001) begin errors++; $display("FAIL reset_result: got %h want 00001001", result_m); end
    reset = 1'b0; valid_m = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(posedge clk); #1;
    checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %b want 0", stall_m); end
  endtask

  task automatic test_directed();
    do_access(1'b1, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0);
    do_access(1'b1, 3'd3, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 2, 0, 0);
    do_access(1'b0, 3'd0, 32'h0000_4002, 32'h1234_5678, 32'h0, 0, 0, 0);
    do_access(1'b1, 3'd4, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 1, 2, 2);
  endtask

  task automatic test_misaligned();
    valid_m = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_op = 3'd2; alu_out = 32'h0000_3001;
    #1;
    checks++; if (ades !== 1'b1) begin errors++; $display("FAIL sh_ades: got %b want 1", ades); end
    checks++; if (badvaddr !== 32'h0000_3001) begin errors++; $display("FAIL sh_badvaddr: got %h want 00003001", badvaddr); end
    checks++; if (data_req !== 1'b0 || stall_m !== 1'b0) begin errors++; $display("FAIL sh_nobus: got req %b stall %b want 0 0", data_req, stall_m); end
    mem_read = 1'b1; mem_write = 1'b0; mem_op = 3'd4; alu_out = 32'h0000_3002;
    #1;
    checks++; if (adel !== 1'b1 || ades !== 1'b0) begin errors++; $display("FAIL lw_adel: got adel %b ades %b want 1 0", adel, ades); end
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      logic [2:0] op; logic [31:0] a; bit ld; int unsigned s; int unsigned off;
      op = 3'($urandom_range(2, 7)); s = size_model(op);
      off = (s == 1) ? ((($urandom % 2) == 0) ? 1 : 3) : $urandom_range(1, 3);
      a = ($urandom & 32'hFFFF_FFFC) | off; ld = 1'($urandom % 2);
      valid_m = 1'b1; mem_read = ld; mem_write = !ld; mem_op = op; alu_out = a;
      #1;
      checks++; if (adel !== ld || ades !== !ld) begin errors++; $display("FAIL rnd_addr_err: got adel %b ades %b want %b %b", adel, ades, ld, !ld); end
      checks++; if (badvaddr !== a) begin errors++; $display("FAIL rnd_badvaddr: got %h want %h", badvaddr, a); end
      checks++; if (data_req !== 1'b0 || stall_m !== 1'b0) begin errors++; $display("FAIL rnd_mis_nobus: got req %b stall %b want 0 0", data_req, stall_m); end
      @(posedge clk); #1;
    end
    valid_m = 1'b0;
    #1;
    checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL mis_idle: got stall %b want 0", stall_m); end
  endtask

  task automatic test_random_access();
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op; logic [31:0] a; int unsigned s;
      op = 3'($urandom_range(0, 7)); s = size_model(op);
      a  = $urandom & ~((32'd1 << s) - 32'd1);
      do_access(1'($urandom % 2), op, a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_flush();
    // flush while stuck in ADDR: request withdrawn
    valid_m = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_op = 3'd4; alu_out = 32'h0000_6000;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    checks++; if (data_req !== 1'b0 || stall_m !== 1'b1) begin errors++; $display("FAIL flush_addr: got req %b stall %b want 0 1", data_req, stall_m); end
    @(posedge clk); #1;
    flush = 1'b0; valid_m = 1'b0;
    #1;
    checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL flush_addr_idle: got stall %b want 0", stall_m); end
    // flush in IDLE blocks the request
    valid_m = 1'b1; flush = 1'b1;
    #1;
    checks++; if (data_req !== 1'b0 || stall_m !== 1'b0) begin errors++; $display("FAIL flush_idle: got req %b stall %b want 0 0", data_req, stall_m); end
    @(posedge clk); #1;
    // flush in DATA, response three cycles later: drained
    flush = 1'b0; alu_out = 32'h0000_7000; data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    checks++; if (stall_m !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL flush_data: got req %b stall %b want 0 1", data_req, stall_m); end
    @(posedge clk); #1;
    flush = 1'b0; valid_m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      data_data_ok = (k == 2); data_rdata = $urandom; alu_out = $urandom;
      #1;
      checks++; if (stall_m !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL drain: got req %b stall %b want 0 1", data_req, stall_m); end
      @(posedge clk); #1;
    end
    data_data_ok = 1'b0; alu_out = 32'h1357_9BDF;
    #1;
    checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL drain_exit: got stall %b want 0", stall_m); end
    checks++; if (result_m !== 32'h1357_9BDF) begin errors++; $display("FAIL drain_result: got %h want 13579bdf", result_m); end
    // flush coincident with data_ok: response discarded, straight to IDLE
    valid_m = 1'b1; mem_read = 1'b1; alu_out = 32'h0000_8000; data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    flush = 1'b0; data_data_ok = 1'b0; valid_m = 1'b0;
    #1;
    checks++; if (stall_m !== 1'b0 || result_m !== 32'h0000_8000) begin errors++; $display("FAIL flush_dataok: got stall %b result %h want 0 00008000", stall_m, result_m); end
    // flush during hold in DONE leaves DONE
    valid_m = 1'b1; mem_read = 1'b1; mem_op = 3'd1; alu_out = 32'h0000_9001; data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_A500;
    @(posedge clk); #1;
    data_data_ok = 1'b0; hold = 1'b1; flush = 1'b1;
    #1;
    checks++; if (result_m !== 32'h0000_00A5) begin errors++; $display("FAIL done_flush_result: got %h want 000000a5", result_m); end
    @(posedge clk); #1;
    hold = 1'b0; flush = 1'b0; valid_m = 1'b0;
    #1;
    checks++; if (result_m !== 32'h0000_9001 || stall_m !== 1'b0) begin errors++; $display("FAIL done_flush_exit: got result %h stall %b want 00009001 0", result_m, stall_m); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_data();
    valid_m = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_op = 3'd4; alu_out = 32'h0000_A000;
    data_addr_ok = 1'b1; data_data_ok = 1'b0;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; reset = 1'b1;
    #1;
    checks++; if (data_req !== 1'b0 || stall_m !== 1'b0) begin errors++; $display("FAIL rst_data: got req %b stall %b want 0 0", data_req, stall_m); end
    @(posedge clk); #1;
    reset = 1'b0; valid_m = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    #1;
    checks++; if (stall_m !== 1'b0 || data_req !== 1'b0) begin errors++; $display("FAIL rst_idle: got req %b stall %b want 0 0", data_req, stall_m); end
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    #1;
    checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL late_dataok: got stall %b want 0", stall_m); end
    do_access(1'b1, 3'd2, 32'h0000_B002, 32'h0, 32'h8001_7FFF, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 3'd0, 32'h0000_C000, 32'h0, 32'h0000_007F, 0, 0, 0);
    do_access(1'b0, 3'd2, 32'h0000_C002, 32'hAAAA_1234, 32'h0, 0, 0, 0);
    do_access(1'b1, 3'd2, 32'h0000_C002, 32'h0, 32'hF00D_0000, 0, 0, 0);
    valid_m = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_random_access();
    test_flush();
    test_reset_in_data();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
